// File: rtl/pe_conv1d_multi_if.sv
// pe_conv1d_multi_if: handshake and data bundle for pe_conv1d_multi.
// The master side loads memories, starts runs and supplies/consumes psums.
// The slave side is the processing element.
interface pe_conv1d_multi_if #(
   parameter int DATA_W = 4,
   parameter int PSUM_W = 8,
   parameter int FA_W   = 3,
   parameter int IA_W   = 3
);
   logic              filter_valid;
   logic              filter_ready;
   logic [FA_W-1:0]   filter_addr;
   logic [DATA_W-1:0] filter_data;
   logic              ifmap_valid;
   logic              ifmap_ready;
   logic [IA_W-1:0]   ifmap_addr;
   logic [DATA_W-1:0] ifmap_data;
   logic              start;
   logic              psum_in_valid;
   logic              psum_in_ready;
   logic [PSUM_W-1:0] psum_in_data;
   logic              psum_out_valid;
   logic              psum_out_ready;
   logic [PSUM_W-1:0] psum_out_data;
   logic              done;

   modport master (
      output filter_valid, filter_addr, filter_data,
      output ifmap_valid, ifmap_addr, ifmap_data,
      output start, psum_in_valid, psum_in_data, psum_out_ready,
      input  filter_ready, ifmap_ready, psum_in_ready,
      input  psum_out_valid, psum_out_data, done
   );

   modport slave (
      input  filter_valid, filter_addr, filter_data,
      input  ifmap_valid, ifmap_addr, ifmap_data,
      input  start, psum_in_valid, psum_in_data, psum_out_ready,
      output filter_ready, ifmap_ready, psum_in_ready,
      output psum_out_valid, psum_out_data, done
   );
endinterface

// File: rtl/pe_conv1d_multi.sv
// pe_conv1d_multi: 1-D convolution processing element with NUM_F filters.
// Filters and ifmap are written while idle; a run walks every output
// position o and filter k (position-major), seeding the accumulator from
// psum_in, doing DEPTH_F multiply-accumulates and emitting one psum.
// Optional macro PE_PSUM_SAT_EN: unsigned saturating accumulation instead
// of modulo-2^PSUM_W wrap.
module pe_conv1d_multi #(
   parameter int DATA_W  = 4,
   parameter int PSUM_W  = 8,
   parameter int DEPTH_I = 5,
   parameter int DEPTH_F = 3,
   parameter int NUM_F   = 2,
   parameter int STRIDE  = 1
) (
   input logic clk,
   input logic reset,
   pe_conv1d_multi_if.slave bus
);
   localparam int NUM_O  = (DEPTH_I - DEPTH_F) / STRIDE + 1;
   localparam int FA_W   = $clog2(NUM_F * DEPTH_F);
   localparam int IA_W   = $clog2(DEPTH_I);
   localparam int O_W    = (NUM_O > 1) ? $clog2(NUM_O) : 1;
   localparam int K_W    = (NUM_F > 1) ? $clog2(NUM_F) : 1;
   localparam int J_W    = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [2:0] {IDLE, FETCH, MAC, EMIT, DONE} state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] ifmap_mem  [DEPTH_I];
   logic [DATA_W-1:0] filter_mem [NUM_F*DEPTH_F];

   logic [O_W-1:0]    o;
   logic [K_W-1:0]    k;
   logic [J_W-1:0]    j;
   logic [PSUM_W-1:0] acc;

   logic [IA_W-1:0]   i_idx;
   logic [FA_W-1:0]   f_idx;
   logic [PROD_W-1:0] prod;
   logic [PSUM_W-1:0] acc_next;
   logic              last_j, last_k, last_o;

   // Memory writes: accepted only while idle, out-of-range addresses dropped.
   always_ff @(posedge clk) begin
      if (bus.filter_valid && bus.filter_ready &&
          (32'(bus.filter_addr) < NUM_F * DEPTH_F))
         filter_mem[bus.filter_addr] <= bus.filter_data;
      if (bus.ifmap_valid && bus.ifmap_ready &&
          (32'(bus.ifmap_addr) < DEPTH_I))
         ifmap_mem[bus.ifmap_addr] <= bus.ifmap_data;
   end

   // Operand addressing, product and next accumulator value.
   always_comb begin
      last_j   = (32'(j) == DEPTH_F - 1);
      last_k   = (32'(k) == NUM_F - 1);
      last_o   = (32'(o) == NUM_O - 1);
      i_idx    = IA_W'(32'(o) * 32'(STRIDE) + 32'(j));
      f_idx    = FA_W'(32'(k) * 32'(DEPTH_F) + 32'(j));
      prod     = PROD_W'(ifmap_mem[i_idx]) * PROD_W'(filter_mem[f_idx]);
`ifdef PE_PSUM_SAT_EN
      acc_next = acc;
      begin : sat_add
         localparam int SUM_W = ((PSUM_W > PROD_W) ? PSUM_W : PROD_W) + 1;
         logic [SUM_W-1:0] sum;
         sum = SUM_W'(acc) + SUM_W'(prod);
         if (sum > SUM_W'({PSUM_W{1'b1}}))
            acc_next = '1;
         else
            acc_next = sum[PSUM_W-1:0];
      end
`else
      acc_next = acc + PSUM_W'(prod);
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = FETCH;
         FETCH:   if (bus.psum_in_valid) state_next = MAC;
         MAC:     if (last_j) state_next = EMIT;
         EMIT:    if (bus.psum_out_ready)
                     state_next = (last_k && last_o) ? DONE : FETCH;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      bus.filter_ready   = 1'b0;
      bus.ifmap_ready    = 1'b0;
      bus.psum_in_ready  = 1'b0;
      bus.psum_out_valid = 1'b0;
      bus.done           = 1'b0;
      bus.psum_out_data  = acc;
      case (state)
         IDLE: begin
            bus.filter_ready = 1'b1;
            bus.ifmap_ready  = 1'b1;
         end
         FETCH:   bus.psum_in_ready  = 1'b1;
         EMIT:    bus.psum_out_valid = 1'b1;
         DONE:    bus.done           = 1'b1;
         default: ;
      endcase
   end

   // Loop counters and accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         o   <= '0;
         k   <= '0;
         j   <= '0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               o <= '0;
               k <= '0;
               j <= '0;
            end
            FETCH: if (bus.psum_in_valid) begin
               acc <= bus.psum_in_data;
               j   <= '0;
            end
            MAC: begin
               acc <= acc_next;
               j   <= last_j ? '0 : j + J_W'(1);
            end
            EMIT: if (bus.psum_out_ready) begin
               if (last_k) begin
                  k <= '0;
                  o <= last_o ? '0 : o + O_W'(1);
               end else begin
                  k <= k + K_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_conv1d_multi.sv
// tb_pe_conv1d_multi: directed checks of pe_conv1d_multi.
// Instance a: default parameters (STRIDE=1, NUM_F=2).
// Instance b: STRIDE=2, NUM_F=1. sel picks which instance is driven/observed.
module tb_pe_conv1d_multi;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       sel, start, f_valid, i_valid, pin_valid, pout_ready;
   logic [2:0] f_addr, i_addr;
   logic [3:0] f_data, i_data;
   logic [7:0] pin_data;

   pe_conv1d_multi_if #(.DATA_W(4), .PSUM_W(8), .FA_W(3), .IA_W(3)) bus_a ();
   pe_conv1d_multi_if #(.DATA_W(4), .PSUM_W(8), .FA_W(2), .IA_W(3)) bus_b ();

   pe_conv1d_multi #(.DATA_W(4), .PSUM_W(8), .DEPTH_I(5), .DEPTH_F(3),
                     .NUM_F(2), .STRIDE(1)) u_dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));

   pe_conv1d_multi #(.DATA_W(4), .PSUM_W(8), .DEPTH_I(5), .DEPTH_F(3),
                     .NUM_F(1), .STRIDE(2)) u_dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   assign bus_a.filter_valid   = f_valid & ~sel;
   assign bus_b.filter_valid   = f_valid & sel;
   assign bus_a.filter_addr    = f_addr;
   assign bus_b.filter_addr    = f_addr[1:0];
   assign bus_a.filter_data    = f_data;
   assign bus_b.filter_data    = f_data;
   assign bus_a.ifmap_valid    = i_valid;
   assign bus_b.ifmap_valid    = i_valid;
   assign bus_a.ifmap_addr     = i_addr;
   assign bus_b.ifmap_addr     = i_addr;
   assign bus_a.ifmap_data     = i_data;
   assign bus_b.ifmap_data     = i_data;
   assign bus_a.start          = start & ~sel;
   assign bus_b.start          = start & sel;
   assign bus_a.psum_in_valid  = pin_valid;
   assign bus_b.psum_in_valid  = pin_valid;
   assign bus_a.psum_in_data   = pin_data;
   assign bus_b.psum_in_data   = pin_data;
   assign bus_a.psum_out_ready = pout_ready;
   assign bus_b.psum_out_ready = pout_ready;

   logic       m_valid, m_done, m_fready, m_iready, m_pin_ready;
   logic [7:0] m_data;
   assign m_valid     = sel ? bus_b.psum_out_valid : bus_a.psum_out_valid;
   assign m_data      = sel ? bus_b.psum_out_data  : bus_a.psum_out_data;
   assign m_done      = sel ? bus_b.done           : bus_a.done;
   assign m_fready    = sel ? bus_b.filter_ready   : bus_a.filter_ready;
   assign m_iready    = sel ? bus_b.ifmap_ready    : bus_a.ifmap_ready;
   assign m_pin_ready = sel ? bus_b.psum_in_ready  : bus_a.psum_in_ready;

   int n_pass   = 0;
   int n_checks = 0;

   logic [7:0] res[$];
   int         first_cyc, gap_bad, n_done;
   int         exp_v [6];

`ifdef PE_PSUM_SAT_EN
   localparam int SAT_EXP = 255;
`else
   localparam int SAT_EXP = 163;
`endif

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic wr_filter(input int a, input int d);
      @(negedge clk);
      f_valid = 1'b1; f_addr = 3'(a); f_data = 4'(d);
      @(negedge clk);
      f_valid = 1'b0;
   endtask

   task automatic wr_ifmap(input int a, input int d);
      @(negedge clk);
      i_valid = 1'b1; i_addr = 3'(a); i_data = 4'(d);
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   // One run on the selected instance. When stall>0, psum_out_ready stays
   // low and start stays high until the first result has been seen for
   // 'stall' cycles; the held value must equal hold_exp every cycle.
   task automatic run(input logic [7:0] pin, input int stall,
                      input logic [7:0] hold_exp);
      int cyc, last, stalled;
      @(negedge clk);
      start = 1'b1; pin_valid = 1'b1; pin_data = pin;
      pout_ready = (stall == 0);
      @(negedge clk);
      if (stall == 0) start = 1'b0;
      res.delete();
      first_cyc = 0; gap_bad = 0; n_done = 0; last = 0; stalled = 0; cyc = 1;
      while (n_done == 0 && cyc <= 200) begin
         if (cyc == 2) check("ready_low_in_run", {m_fready, m_iready}, 0);
         if (m_valid) begin
            if (!pout_ready) begin
               check("stall_hold_data", m_data, hold_exp);
               stalled++;
               if (stalled == stall) begin
                  pout_ready = 1'b1;
                  start      = 1'b0;
               end
            end
            if (pout_ready) begin
               if (res.size() == 0) first_cyc = cyc;
               else if (stall == 0 && cyc - last != 5) gap_bad++;
               last = cyc;
               res.push_back(m_data);
            end
         end
         if (m_done) n_done++;
         @(negedge clk);
         cyc++;
      end
      check("done_seen", n_done, 1);
      check("done_single_cycle", m_done, 0);
      check("back_to_idle", m_fready, 1);
      pin_valid = 1'b0;
   endtask

   task automatic check_res(input string tag, input int n);
      check({tag, "_count"}, res.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_%0d", tag, i),
               (i < res.size()) ? 32'(res[i]) : 32'hFFFF_FFFF, exp_v[i]);
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; start = 1'b0;
      f_valid = 1'b0; f_addr = '0; f_data = '0;
      i_valid = 1'b0; i_addr = '0; i_data = '0;
      pin_valid = 1'b0; pin_data = '0; pout_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_filter_ready", m_fready, 1);
      check("rst_ifmap_ready", m_iready, 1);
      check("rst_out_valid", m_valid, 0);
      check("rst_pin_ready", m_pin_ready, 0);
      check("rst_done", m_done, 0);
      reset = 1'b0;

      // Instance a: k0={1,2,3}, k1={0,1,0}; ifmap={1,2,3,4,5} (shared).
      wr_filter(0, 1); wr_filter(1, 2); wr_filter(2, 3);
      wr_filter(3, 0); wr_filter(4, 1); wr_filter(5, 0);
      wr_filter(6, 15); wr_filter(7, 15);
      for (int i = 0; i < 5; i++) wr_ifmap(i, i + 1);
      wr_ifmap(5, 15); wr_ifmap(6, 15); wr_ifmap(7, 15);

      exp_v = '{14, 2, 20, 3, 26, 4};
      run(8'd0, 0, 8'd0);
      check_res("basic", 6);
      check("first_latency", first_cyc, 5);
      check("result_spacing", gap_bad, 0);

      exp_v = '{114, 102, 120, 103, 126, 104};
      run(8'd100, 0, 8'd0);
      check_res("psum_in_100", 6);

      exp_v = '{14, 2, 20, 3, 26, 4};
      run(8'd0, 6, 8'd14);
      check_res("stall", 6);

      // Reset during MAC of the second output, then a clean rerun.
      @(negedge clk);
      start = 1'b1; pin_valid = 1'b1; pin_data = '0; pout_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_out_valid", m_valid, 0);
      check("midrst_pin_ready", m_pin_ready, 0);
      check("midrst_done", m_done, 0);
      check("midrst_filter_ready", m_fready, 1);
      begin
         int stale;
         stale = 0;
         repeat (5) begin
            @(negedge clk);
            if (m_valid || m_done) stale++;
         end
         check("midrst_no_stale", stale, 0);
      end
      pin_valid = 1'b0;
      run(8'd0, 0, 8'd0);
      check_res("rerun", 6);

      // Instance b: STRIDE=2, single filter {1,2,3}.
      sel = 1'b1;
      wr_filter(0, 1); wr_filter(1, 2); wr_filter(2, 3); wr_filter(3, 15);
      exp_v = '{14, 26, 0, 0, 0, 0};
      run(8'd0, 0, 8'd0);
      check_res("stride2", 2);
      check("stride2_latency", first_cyc, 5);

      // All-15 data on instance a: 3*225 wraps to 163, saturates to 255.
      sel = 1'b0;
      for (int i = 0; i < 6; i++) wr_filter(i, 15);
      for (int i = 0; i < 5; i++) wr_ifmap(i, 15);
      exp_v = '{SAT_EXP, SAT_EXP, SAT_EXP, SAT_EXP, SAT_EXP, SAT_EXP};
      run(8'd0, 0, 8'd0);
      check_res("all15", 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
